// File: rtl/stream_burst_fifo.sv
// stream_burst_fifo
// Burst-admitting first-word-fall-through FIFO between an AXI R-channel tap
// and an AXI4-Stream master. A burst is admitted only when a worst-case
// burst fits, and once admitted it is never back-pressured, so the tap never
// has to replay its metadata beat.
// Optional feature: define STREAM_BURST_FIFO_STORE_FWD_EN for store-and-forward
// emission (a burst leaves only after its last beat has been stored).
module stream_burst_fifo #(
    parameter int DATA_WIDTH      = 128,
    parameter int DEPTH           = 64,
    parameter int MAX_BURST_BEATS = 17
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    input  logic                    s_last,
    input  logic                    s_in_progress,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int EW  = DATA_WIDTH + 1;
    // Beat counter has headroom past the budget so overruns stay visible; it saturates.
    localparam int BCW = $clog2(MAX_BURST_BEATS + 1) + 1;

    localparam logic [FW-1:0]  DEPTH_L  = FW'(DEPTH);
    localparam logic [FW-1:0]  BUDGET_L = FW'(MAX_BURST_BEATS);
    localparam logic [BCW-1:0] BUDGET_C = BCW'(MAX_BURST_BEATS);

    // Parameter sanity: a worst-case burst must fit, and pointers wrap naturally.
    generate
        if (DEPTH < MAX_BURST_BEATS) begin : g_depth_chk
            $error("stream_burst_fifo: DEPTH must be >= MAX_BURST_BEATS");
        end
        if ((DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_chk
            $error("stream_burst_fifo: DEPTH must be a power of 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [EW-1:0]   r_rd_data;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_ptr_next;
    logic [FW-1:0]   r_fill;
    logic [FW-1:0]   r_pkt_cnt;
    logic [BCW-1:0]  r_beat_cnt;
    logic            r_overflow;

    logic [FW-1:0]   w_free;
    logic            w_admit;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_wr_en;
    logic            w_pop;
    logic            w_pkt_inc;
    logic            w_pkt_dec;

    // Occupancy is the single source of truth for full/empty; pointer
    // equality is ambiguous once both pointers wrap.
    assign w_full   = (r_fill == DEPTH_L);
    assign w_empty  = (r_fill == '0);
    assign w_free   = DEPTH_L - r_fill;
    assign w_admit  = (w_free >= BUDGET_L);

    // A beat accepted while full can only be an over-budget beat of an
    // admitted burst; it is acknowledged to the tap but discarded.
    assign w_accept = s_valid & s_ready;
    assign w_wr_en  = w_accept & ~w_full;
    assign w_pop    = m_axis_tvalid & m_axis_tready;

    assign w_pkt_inc = w_wr_en & s_last;
    assign w_pkt_dec = w_pop & m_axis_tlast;

    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    assign m_axis_tdata = r_rd_data[DATA_WIDTH-1:0];
    assign m_axis_tlast = r_rd_data[DATA_WIDTH];
    assign fill_level   = r_fill;
    assign overflow     = r_overflow;

`ifdef STREAM_BURST_FIFO_STORE_FWD_EN
    // Hold the head back until at least one complete burst is stored.
    assign m_axis_tvalid = ~w_empty & (r_pkt_cnt != '0);
`else
    // Cut-through: present the head as soon as anything is stored.
    assign m_axis_tvalid = ~w_empty;
`endif

    // Tap ready: budget check while idle, unconditional inside a burst, low in reset.
    always_comb begin
        s_ready = 1'b0;
        if (resetn) begin
            case (r_state)
                IDLE:    s_ready = w_admit;
                BURST:   s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    // Admission FSM next state: enter BURST on a non-last beat, leave on the last.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !s_last) begin
                    w_state_next = BURST;
                end
            end
            BURST: begin
                if (w_accept && s_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and per-burst beat counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (r_state == IDLE) begin
                    r_beat_cnt <= s_last ? '0 : BCW'(1);
                end else if (s_last) begin
                    r_beat_cnt <= '0;
                end else if (r_beat_cnt != '1) begin
                    r_beat_cnt <= r_beat_cnt + BCW'(1);
                end
            end
        end
    end

    // Pointers, occupancy, complete-burst count and sticky overrun flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_pkt_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;

            case ({w_wr_en, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase

            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + FW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - FW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase

            if (w_accept && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    // Registered read of the next head entry; a beat being written into that
    // very slot is forwarded so it appears on the stream one cycle after its write.
    always_ff @(posedge clk) begin
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_next)) begin
            r_rd_data <= {s_last, s_data};
        end else begin
            r_rd_data <= r_mem[w_rd_ptr_next];
        end
    end

    // Protocol checks: the tap must not claim mid-burst while we are idle, and
    // a drop can only happen once a burst has used up its whole budget.
    a_idle_in_progress: assert property (
        @(posedge clk) disable iff (!resetn)
        !((r_state == IDLE) && s_in_progress)
    );

    a_overrun_budget: assert property (
        @(posedge clk) disable iff (!resetn)
        (w_accept && w_full) |-> (r_beat_cnt >= BUDGET_C)
    );

endmodule

// File: tb/tb_stream_burst_fifo.sv
// tb_stream_burst_fifo
// Scoreboard bench: the stimulus side pushes every beat that should be stored
// into exp_q; an independent monitor pops and compares on each stream handshake.
module tb_stream_burst_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 64;
    localparam int MB    = 17;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   s_valid = 1'b0;
    logic                   s_last = 1'b0;
    logic                   s_in_progress = 1'b0;
    logic [DW-1:0]          s_data = '0;
    logic                   s_ready;
    logic [DW-1:0]          m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tlast;
    logic                   m_axis_tready = 1'b0;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow;

    int checks = 0;
    int errors = 0;
    int max_fill = 0;
    int beats_out = 0;
    bit chk_fill = 1'b0;
    bit rand_rdy = 1'b0;
    logic [DW:0] exp_q[$];

    stream_burst_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .MAX_BURST_BEATS (MB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_in_progress (s_in_progress),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .fill_level    (fill_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int b, input int i);
        logic [63:0] lo;
        lo = 64'h0123_4567_89AB_CDEF ^ 64'(b * 131 + i);
        return {16'hCAFE, b[15:0], i[15:0], 16'h0000, lo};
    endfunction

    // Monitor: compare each handshaked beat against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", {m_axis_tlast, m_axis_tdata});
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                beats_out++;
                $display("beat %0d out: last=%0d data=%h", beats_out, m_axis_tlast, m_axis_tdata);
                check("stream_beat", {m_axis_tlast, m_axis_tdata}, e);
            end
        end
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    end

    // Occupancy must equal the number of stored-but-not-yet-emitted beats.
    always @(posedge clk) begin
        #2;
        if (chk_fill) check("fill_level", DW'(fill_level), DW'(exp_q.size()));
    end

    // Random back-pressure for the wrap test.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Present one beat and hold it until accepted; call at posedge+1.
    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit inp, input bit stored);
        int n;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        s_in_progress = inp;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        if (s_ready !== 1'b0 || 1) begin
        end
        if (stored) exp_q.push_back({last, d});
    endtask

    task automatic go_idle();
        s_valid = 1'b0;
        s_last = 1'b0;
        s_in_progress = 1'b0;
    endtask

    task automatic send_burst(input int b, input int len);
        for (int i = 0; i < len; i++) begin
            send_beat(mk(b, i), (i == len - 1), (i != 0), 1'b1);
        end
        go_idle();
    endtask

    task automatic drain();
        int n;
        m_axis_tready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || fill_level != '0) && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || fill_level != '0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got fill %0d queue %0d expected 0", fill_level, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #11;
        check("rst_s_ready", DW'(s_ready), DW'(0));
        check("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_fill", DW'(fill_level), DW'(0));
        check("rst_overflow", DW'(overflow), DW'(0));
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready", DW'(s_ready), DW'(1));
        chk_fill = 1'b1;

        // Four-beat burst, tready=1: latency and ordering
        m_axis_tready = 1'b1;
        check("tvalid_empty", DW'(m_axis_tvalid), DW'(0));
        for (int i = 0; i < 4; i++) begin
            send_beat(mk(1, i), (i == 3), (i != 0), 1'b1);
`ifdef STREAM_BURST_FIFO_STORE_FWD_EN
            check("sf_tvalid_after_write", DW'(m_axis_tvalid), DW'(i == 3));
`else
            check("ct_tvalid_after_write", DW'(m_axis_tvalid), DW'(1));
`endif
        end
        go_idle();
`ifdef STREAM_BURST_FIFO_STORE_FWD_EN
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("sf_back_to_back", DW'(m_axis_tvalid), DW'(1));
        end
`endif
        drain();

        // Admission threshold with tready=0
        m_axis_tready = 1'b0;
        send_burst(2, 17);
        send_burst(3, 17);
        send_burst(4, 13);
        check("ready_at_47", DW'(s_ready), DW'(1));
        send_burst(5, 1);
        check("fill_48", DW'(fill_level), DW'(48));
        check("ready_at_48", DW'(s_ready), DW'(0));
        m_axis_tready = 1'b1;
        check("ready_before_pop", DW'(s_ready), DW'(0));
        @(posedge clk); #1;
        check("fill_after_pop", DW'(fill_level), DW'(47));
        check("ready_returns", DW'(s_ready), DW'(1));
        drain();

        // Wrap: 200 beats with random back-pressure
        begin
            int total;
            int b;
            int len;
            total = 0;
            b = 10;
            rand_rdy = 1'b1;
            while (total < 200) begin
                len = 1 + (b % 17);
                if (len > 200 - total) len = 200 - total;
                send_burst(b, len);
                total += len;
                b++;
            end
            rand_rdy = 1'b0;
            @(posedge clk); #1;
            drain();
        end
        check("wrap_max_fill_le_64", DW'(max_fill <= 64), DW'(1));
        check("wrap_overflow", DW'(overflow), DW'(0));

`ifndef STREAM_BURST_FIFO_STORE_FWD_EN
        // Overrun: 20-beat burst at fill 47, beats 18..20 dropped
        m_axis_tready = 1'b0;
        send_burst(20, 17);
        send_burst(21, 17);
        send_burst(22, 13);
        for (int i = 0; i < 20; i++) begin
            if (i != 0) check("overrun_ready_held", DW'(s_ready), DW'(1));
            send_beat(mk(30, i), (i == 19), (i != 0), (i < 17));
        end
        go_idle();
        check("overrun_flag", DW'(overflow), DW'(1));
        check("overrun_fill", DW'(fill_level), DW'(64));
        check("overrun_idle_full_ready", DW'(s_ready), DW'(0));
        drain();
        check("overrun_sticky", DW'(overflow), DW'(1));
`endif

        // Reset asserted mid-burst at fill 10
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_beat(mk(40, i), 1'b0, (i != 0), 1'b1);
        end
        check("midburst_fill", DW'(fill_level), DW'(10));
        check("midburst_ready", DW'(s_ready), DW'(1));
        chk_fill = 1'b0;
        #2;
        resetn = 1'b0;
        go_idle();
        #1;
        check("async_rst_s_ready", DW'(s_ready), DW'(0));
        check("async_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("async_rst_fill", DW'(fill_level), DW'(0));
        check("async_rst_overflow", DW'(overflow), DW'(0));
        exp_q.delete();
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        check("release_ready", DW'(s_ready), DW'(1));
        chk_fill = 1'b1;
        send_burst(41, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
